score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 9, meaning the score (1..9) that ends the game.
REQ-002 SHALL have parameter REFRESH_BITS, default 18, meaning the width of the seven-segment refresh counter.
REQ-003 SHALL have port clk, input, 1, meaning the 100 MHz system clock and the only clock.
REQ-004 SHALL have port reset, input, 1, meaning a synchronous, active-low reset.
REQ-005 SHALL have port launch, input, 1, meaning the serve request (btnC level, already synchronised).
REQ-006 SHALL have port left_hit, input, 1, meaning the ball reached the left wall; it is a level held high until the drawer returns to its start state.
REQ-007 SHALL have port right_hit, input, 1, meaning the ball reached the right wall; it is a level with the same behaviour as left_hit.
REQ-008 SHALL have port seg, output, 7, meaning segments a..g, active-low.
REQ-009 SHALL have port an, output, 4, meaning digit anodes, active-low.
REQ-010 SHALL have port dp, output, 1, meaning the decimal point, active-low; it is held at 1.
REQ-011 SHALL have port led, output, 16, meaning score and status LEDs.
REQ-012 SHALL have port game_over, output, 1, meaning the state is GAME_OVER.
REQ-013 SHALL have port winner, output, 2, meaning 00 none, 01 left player, 10 right player.

Function
REQ-014 SHALL register left_hit, right_hit and launch once and detect rising edges against the registered copy; all scoring acts on those edges only.
REQ-015 SHALL implement the states IDLE, PLAY and GAME_OVER.
REQ-016 SHALL move IDLE->PLAY on a launch rising edge.
REQ-017 SHALL move PLAY->GAME_OVER in the cycle after either score reaches WIN_SCORE.
REQ-018 SHALL, on a launch rising edge in GAME_OVER, clear both scores and winner and move to IDLE.
REQ-019 SHALL increment right_score by 1 on a left_hit rising edge in PLAY, and left_score by 1 on a right_hit rising edge in PLAY.
REQ-020 SHALL change neither score when left_hit and right_hit rise in the same cycle.
REQ-021 SHALL ignore hit edges in IDLE and GAME_OVER.
REQ-022 SHALL hold each score in 4 bits, range 0..WIN_SCORE, saturating with no wrap.
REQ-023 SHALL set winner in the same cycle it enters GAME_OVER and hold it until cleared.
REQ-024 SHALL update score registers with 1-cycle latency from the registered hit edge, i.e. 2 clk after the input rises.
REQ-025 SHALL drive game_over high exactly while in GAME_OVER.
REQ-026 SHALL free-run the refresh counter, wrapping at 2^REFRESH_BITS; its top 2 bits select the active digit 0..3, and exactly one an bit is low at a time.
REQ-027 SHALL show left_score on digit 3 and right_score on digit 0.
REQ-028 SHALL blank digits 2 and 1 in IDLE and PLAY (seg=7'h7F).
REQ-029 SHALL, in GAME_OVER, show the winner number (1 or 2) on digit 1 and keep digit 2 blank.
REQ-030 SHALL drive led[15:12]=left_score, led[3:0]=right_score, led[8]=game_over and led[7]=(state==PLAY), with all other led bits 0.

Reset
REQ-031 SHALL, while reset=0 at a clk edge, return to state IDLE with both scores 0, winner 00, game_over 0, refresh counter 0 and the edge registers cleared to 0.
REQ-032 SHALL drive outputs after reset as an=4'b1110, seg=pattern "0" (7'b1000000), dp=1 and led=0.
REQ-033 SHALL treat a reset asserted mid-game, including in GAME_OVER, as a full clear; a hit level still high on release SHALL NOT score until it falls and rises again.

Structure
REQ-034 SHALL place the state encoding, WIN_SCORE default, blank pattern and digit-to-segment constants in a shared package pong_pkg.
REQ-035 SHALL perform digit decode in one combinational sub-module, seg7_decode (4-bit value in, 7-bit active-low segments out, value 15 = blank).

Verification
REQ-036 SHALL verify: reset, launch pulse, then left_hit high for 100 clk -> right_score=1 (exactly one increment), led[3:0]=4'h1, state PLAY.
REQ-037 SHALL verify: in PLAY, left_hit and right_hit rise on the same clk -> both scores unchanged.
REQ-038 SHALL verify: 9 right_hit pulses in PLAY -> left_score=9, game_over=1 one clk later, winner=01, digit 1 shows "1", a further hit gives no change.
REQ-039 SHALL verify: in GAME_OVER, a launch edge -> scores 0, winner 00, state IDLE; a hit in IDLE gives no score.
REQ-040 SHALL verify: with REFRESH_BITS=4, an cycles 1110,1101,1011,0111 every 4 clk, never two bits low.
REQ-041 SHALL verify: reset=0 pulsed at score 5-3 with left_hit held high -> all zero, and no score until left_hit toggles.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong score keeper.
//   state_t      : game state encoding (IDLE, PLAY, GAME_OVER)
//   WIN_SCORE_DEFAULT : score that ends a game unless overridden
//   SEG_*        : active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   WINNER_*     : encoding of the winner output
package pong_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PLAY      = 2'd1,
      ST_GAME_OVER = 2'd2
   } state_t;

   localparam int WIN_SCORE_DEFAULT = 9;

   localparam logic [1:0] WINNER_NONE  = 2'b00;
   localparam logic [1:0] WINNER_LEFT  = 2'b01;
   localparam logic [1:0] WINNER_RIGHT = 2'b10;

   // Digit value that the decoder renders as an unlit digit.
   localparam logic [3:0] DIGIT_BLANK = 4'hF;
   localparam logic [6:0] SEG_BLANK   = 7'h7F;

   // Patterns for decimal digits 0..9, active-low {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_DIGITS [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment decoder.
//   value : 4-bit digit value; 0..9 shown as decimal, anything else blank
//   seg   : active-low segments {g,f,e,d,c,b,a}
module seg7_decode
   import pong_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] seg
);

   always_comb begin
      // NOTE: assign a default first so every path drives seg and no latch is inferred.
      seg = SEG_BLANK;
      if (value <= 4'd9) begin
         seg = SEG_DIGITS[value];
      end
   end

endmodule

// File: rtl/score_keeper.sv
// Pong score keeper: edge-detects wall hits and serve requests, keeps both
// scores, runs the IDLE/PLAY/GAME_OVER game flow and multiplexes the scores
// onto a four-digit seven-segment display.
//   clk       : system clock
//   reset     : synchronous, active-low
//   launch    : serve request level
//   left_hit  : ball reached left wall (level) -> point for right player
//   right_hit : ball reached right wall (level) -> point for left player
//   seg/an/dp : active-low display drive (digit 3 = left, digit 0 = right,
//               digit 1 = winner number in GAME_OVER)
//   led       : [15:12] left score, [8] game over, [7] playing, [3:0] right score
//   game_over : high while in GAME_OVER
//   winner    : 00 none, 01 left, 10 right
module score_keeper
   import pong_pkg::*;
#(
   parameter int WIN_SCORE    = WIN_SCORE_DEFAULT,
   parameter int REFRESH_BITS = 18
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        launch,
   input  logic        left_hit,
   input  logic        right_hit,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        dp,
   output logic [15:0] led,
   output logic        game_over,
   output logic [1:0]  winner
);

   localparam logic [3:0] WIN = 4'(WIN_SCORE);

   state_t                  state_q, state_d;
   logic [3:0]              left_score_q, left_score_d;
   logic [3:0]              right_score_q, right_score_d;
   logic [1:0]              winner_q, winner_d;
   logic [REFRESH_BITS-1:0] refresh_q, refresh_d;

   // Input copies and the registered rising-edge pulses derived from them.
   // Scoring acts on the registered pulse, so a score lands two clocks after
   // the input rises.
   logic left_hit_q, right_hit_q, launch_q;
   logic left_rise_q, left_rise_d;
   logic right_rise_q, right_rise_d;
   logic launch_rise_q, launch_rise_d;

   logic [1:0] digit_sel;
   logic [3:0] digit_value;
   logic [3:0] winner_num;

   always_comb begin
      left_rise_d   = left_hit  & ~left_hit_q;
      right_rise_d  = right_hit & ~right_hit_q;
      launch_rise_d = launch    & ~launch_q;
   end

   always_comb begin
      state_d       = state_q;
      left_score_d  = left_score_q;
      right_score_d = right_score_q;
      winner_d      = winner_q;
      refresh_d     = refresh_q + REFRESH_BITS'(1);

      unique case (state_q)
         ST_IDLE: begin
            if (launch_rise_q) begin
               state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            // A score at WIN ends the game on the next clock; no further
            // points are taken meanwhile, which also keeps both scores
            // saturated at WIN.
            if (left_score_q == WIN) begin
               state_d  = ST_GAME_OVER;
               winner_d = WINNER_LEFT;
            end else if (right_score_q == WIN) begin
               state_d  = ST_GAME_OVER;
               winner_d = WINNER_RIGHT;
            end else if (left_rise_q ^ right_rise_q) begin
               // Simultaneous hits on both walls cancel out.
               if (left_rise_q) begin
                  right_score_d = right_score_q + 4'd1;
               end else begin
                  left_score_d = left_score_q + 4'd1;
               end
            end
         end
         ST_GAME_OVER: begin
            if (launch_rise_q) begin
               state_d       = ST_IDLE;
               left_score_d  = 4'd0;
               right_score_d = 4'd0;
               winner_d      = WINNER_NONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         left_score_q  <= 4'd0;
         right_score_q <= 4'd0;
         winner_q      <= WINNER_NONE;
         refresh_q     <= '0;
         left_hit_q    <= 1'b0;
         right_hit_q   <= 1'b0;
         launch_q      <= 1'b0;
         left_rise_q   <= 1'b0;
         right_rise_q  <= 1'b0;
         launch_rise_q <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values.
         state_q       <= state_d;
         left_score_q  <= left_score_d;
         right_score_q <= right_score_d;
         winner_q      <= winner_d;
         refresh_q     <= refresh_d;
         left_hit_q    <= left_hit;
         right_hit_q   <= right_hit;
         launch_q      <= launch;
         left_rise_q   <= left_rise_d;
         right_rise_q  <= right_rise_d;
         launch_rise_q <= launch_rise_d;
      end
   end

   // Display multiplexing: the top two refresh bits pick one digit at a time.
   assign digit_sel  = refresh_q[REFRESH_BITS-1 -: 2];
   assign winner_num = (winner_q == WINNER_RIGHT) ? 4'd2 : 4'd1;

   always_comb begin
      an          = 4'b1111;
      digit_value = DIGIT_BLANK;
      case (digit_sel)
         2'd0: begin
            an          = 4'b1110;
            digit_value = right_score_q;
         end
         2'd1: begin
            an          = 4'b1101;
            digit_value = (state_q == ST_GAME_OVER) ? winner_num : DIGIT_BLANK;
         end
         2'd2: begin
            an          = 4'b1011;
            digit_value = DIGIT_BLANK;
         end
         2'd3: begin
            an          = 4'b0111;
            digit_value = left_score_q;
         end
      endcase
   end

   seg7_decode u_seg7_decode (
      .value (digit_value),
      .seg   (seg)
   );

   assign dp        = 1'b1;
   assign game_over = (state_q == ST_GAME_OVER);
   assign winner    = winner_q;
   assign led       = {left_score_q, 3'b000, game_over, (state_q == ST_PLAY),
                       3'b000, right_score_q};

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper (WIN_SCORE=9, REFRESH_BITS=4).
module tb_score_keeper;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        launch = 1'b0;
   logic        left_hit = 1'b0;
   logic        right_hit = 1'b0;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;
   logic [15:0] led;
   logic        game_over;
   logic [1:0]  winner;

   always #5 clk = ~clk;

   score_keeper #(
      .WIN_SCORE    (9),
      .REFRESH_BITS (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .launch    (launch),
      .left_hit  (left_hit),
      .right_hit (right_hit),
      .seg       (seg),
      .an        (an),
      .dp        (dp),
      .led       (led),
      .game_over (game_over),
      .winner    (winner)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       tag;
      logic [15:0] led;
      logic        go;
      logic [1:0]  win;
   } exp_t;

   exp_t sb_q[$];

   // Reference model of the game, advanced in spec terms.
   int         m_left, m_right;
   bit         m_play, m_go;
   logic [1:0] m_win;

   function automatic logic [15:0] led_of(input int l, input int r, input bit go, input bit play);
      return {4'(l), 3'b000, go, play, 3'b000, 4'(r)};
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_left = 0; m_right = 0; m_play = 0; m_go = 0; m_win = 2'b00;
   endtask

   task automatic model_hit(input bit is_left);
      if (m_play && m_left < 9 && m_right < 9) begin
         if (is_left) m_right++;
         else         m_left++;
      end
   endtask

   task automatic model_settle();
      if (m_play && (m_left == 9 || m_right == 9)) begin
         m_play = 0;
         m_go   = 1;
         m_win  = (m_left == 9) ? 2'b01 : 2'b10;
      end
   endtask

   task automatic push_expect(input string tag);
      exp_t e;
      e.tag = tag;
      e.led = led_of(m_left, m_right, m_go, m_play);
      e.go  = m_go;
      e.win = m_win;
      sb_q.push_back(e);
   endtask

   task automatic compare_next();
      exp_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL sb_underflow observed=empty expected=entry");
         return;
      end
      e = sb_q.pop_front();
      check({e.tag, "_led"},    32'(led),       32'(e.led));
      check({e.tag, "_go"},     32'(game_over), 32'(e.go));
      check({e.tag, "_winner"}, 32'(winner),    32'(e.win));
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b0;
      clk_n(2);
      model_clear();
      sb_q.delete();
      check({tag, "_led"},    32'(led),       32'h0);
      check({tag, "_go"},     32'(game_over), 32'h0);
      check({tag, "_winner"}, 32'(winner),    32'h0);
      check({tag, "_an"},     32'(an),        32'he);
      check({tag, "_seg"},    32'(seg),       32'h40);
      check({tag, "_dp"},     32'(dp),        32'h1);
      reset = 1'b1;
   endtask

   task automatic launch_pulse(input string tag);
      launch = 1'b1;
      if (m_go) model_clear();
      else if (!m_play) m_play = 1;
      push_expect(tag);
      clk_n(2);
      compare_next();
      launch = 1'b0;
      clk_n(2);
   endtask

   // Score lands two clocks after the rise; a winning score moves to
   // GAME_OVER one clock after that.
   task automatic hit_pulse(input bit is_left, input string tag);
      if (is_left) left_hit = 1'b1;
      else         right_hit = 1'b1;
      model_hit(is_left);
      push_expect({tag, "_score"});
      model_settle();
      push_expect({tag, "_state"});
      clk_n(2);
      compare_next();
      clk_n(1);
      compare_next();
      left_hit  = 1'b0;
      right_hit = 1'b0;
      clk_n(2);
   endtask

   // Waits (bounded) until the given digit is active, then checks its pattern.
   task automatic check_digit(input int digit, input logic [6:0] exp_seg, input string tag);
      logic [3:0] target;
      bit         found;
      target = ~(4'b0001 << digit);
      found  = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (an == target) found = 1;
         else clk_n(1);
      end
      check({tag, "_found"}, 32'(found), 32'h1);
      check({tag, "_seg"},   32'(seg),   32'(exp_seg));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_clear();
      do_reset("rst0");

      // Refresh scan: counter restarts at 0, each digit lasts 4 clocks.
      for (int k = 1; k <= 16; k++) begin
         int         digit;
         logic [3:0] exp_an;
         clk_n(1);
         digit  = (k % 16) / 4;
         exp_an = ~(4'b0001 << digit);
         check($sformatf("scan%0d_an", k), 32'(an), 32'(exp_an));
         check($sformatf("scan%0d_onelow", k), 32'($countones(~an)), 32'd1);
         check($sformatf("scan%0d_seg", k), 32'(seg),
               (digit == 0 || digit == 3) ? 32'h40 : 32'h7f);
      end

      launch_pulse("launch1");

      // Held left_hit: one increment, landing two clocks after the rise.
      left_hit = 1'b1;
      clk_n(1);
      check("lat_1clk", 32'(led), 32'(led_of(0, 0, 0, 1)));
      clk_n(1);
      model_hit(1'b1);
      check("lat_2clk", 32'(led), 32'(led_of(m_left, m_right, m_go, m_play)));
      push_expect("hold100");
      clk_n(98);
      compare_next();
      check("hold100_right", 32'(led[3:0]), 32'h1);
      left_hit = 1'b0;
      clk_n(2);

      // Both walls on the same clock: no change.
      left_hit  = 1'b1;
      right_hit = 1'b1;
      push_expect("both");
      clk_n(4);
      compare_next();
      left_hit  = 1'b0;
      right_hit = 1'b0;
      clk_n(2);

      for (int i = 1; i <= 9; i++) hit_pulse(1'b0, $sformatf("rhit%0d", i));
      check_digit(1, 7'h79, "win_left_d1");
      check_digit(3, 7'h10, "win_left_d3");
      check_digit(0, 7'h79, "win_left_d0");
      check_digit(2, 7'h7f, "win_left_d2");

      hit_pulse(1'b0, "go_rhit");
      hit_pulse(1'b1, "go_lhit");

      launch_pulse("restart");
      hit_pulse(1'b1, "idle_lhit");
      hit_pulse(1'b0, "idle_rhit");

      // Build 5-3 with left_hit left high, then reset mid-game.
      launch_pulse("launch2");
      for (int i = 1; i <= 5; i++) hit_pulse(1'b0, $sformatf("r53_%0d", i));
      for (int i = 1; i <= 2; i++) hit_pulse(1'b1, $sformatf("l53_%0d", i));
      left_hit = 1'b1;
      model_hit(1'b1);
      clk_n(3);
      check("score53", 32'(led), 32'(led_of(5, 3, 0, 1)));
      do_reset("rst_mid");
      clk_n(4);
      check("rst_mid_idle", 32'(led), 32'h0);
      launch_pulse("launch3");
      push_expect("held_noscore");
      clk_n(6);
      compare_next();
      left_hit = 1'b0;
      clk_n(2);
      hit_pulse(1'b1, "retoggle");

      // Right player wins.
      for (int i = 2; i <= 9; i++) hit_pulse(1'b1, $sformatf("lhit%0d", i));
      check_digit(1, 7'h24, "win_right_d1");
      check_digit(0, 7'h10, "win_right_d0");

      do_reset("rst_go");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
